vga_timing_gen: RTL and testbench

Raster timing generator that produces the DrawX/DrawY scan coordinates, the divided `vga_clk`, and the `blank`/`hs`/`vs` signals. The sprite renderers consume these coordinates and return registered pixel colour one `vga_clk` later. This block sits at the top of the video path and drives every sprite and background layer. Its sync and blank outputs are delayed by a programmable number of pixel ticks so they line up with the registered sprite colour reaching the DAC.

---
 rtl/vga_timing_gen.sv | 70 +++++++
 tb/tb_vga_timing_gen.sv | 138 +++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster counters, Clk/2 pixel clock, and sync/blank delayed to align with registered sprite colour.
module vga_timing_gen #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int SYNC_DELAY = 1
) (
  input  logic       Clk,
  input  logic       Reset,
  output logic       vga_clk,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       hs,
  output logic       vs,
  output logic       blank,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_count
);
  localparam logic [9:0] H_LAST = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] V_LAST = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] HS_ON  = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_OFF = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_ON  = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_OFF = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
  localparam int D = (SYNC_DELAY > 0) ? SYNC_DELAY : 1;
  logic       t;
  logic       h_wrap;
  logic       v_wrap;
  logic [2:0] raw;
  logic [2:0] dly [D];
  assign vga_clk = t;
  assign h_wrap  = t && DrawX == H_LAST;
  assign v_wrap  = h_wrap && DrawY == V_LAST;
  assign raw = {~(DrawX >= HS_ON && DrawX < HS_OFF),
                ~(DrawY >= VS_ON && DrawY < VS_OFF),
                DrawX < H_VIS && DrawY < V_VIS};
  always_ff @(posedge Clk)
    if (Reset) begin
      t           <= 1'b0;
      DrawX       <= '0;
      DrawY       <= '0;
      frame_count <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      t           <= ~t;
      line_start  <= h_wrap;
      frame_start <= v_wrap;
      if (t) DrawX <= h_wrap ? '0 : DrawX + 10'd1;
      if (h_wrap) DrawY <= v_wrap ? '0 : DrawY + 10'd1;
      if (v_wrap) frame_count <= frame_count + 8'd1;
    end
  // stages hold {hs, vs, blank}; reset value is the inactive pattern
  always_ff @(posedge Clk)
    if (Reset) begin
      for (int i = 0; i < D; i++) dly[i] <= 3'b110;
    end else if (t) begin
      dly[0] <= raw;
      for (int i = 1; i < D; i++) dly[i] <= dly[i-1];
    end
  assign {hs, vs, blank} = (SYNC_DELAY == 0) ? raw : dly[D-1];
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of default-size, zero/three-delay and shrunken-raster generators.
module tb_vga_timing_gen;
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;
  logic a_vclk, a_hs, a_vs, a_blank, a_ls, a_fs;
  logic b_vclk, b_hs, b_vs, b_blank, b_ls, b_fs;
  logic c_vclk, c_hs, c_vs, c_blank, c_ls, c_fs;
  logic s_vclk, s_hs, s_vs, s_blank, s_ls, s_fs;
  logic [9:0] a_x, a_y, b_x, b_y, c_x, c_y, s_x, s_y;
  logic [7:0] a_fc, b_fc, c_fc, s_fc;
  vga_timing_gen #(.SYNC_DELAY(1)) da (.Clk(Clk), .Reset(Reset), .vga_clk(a_vclk), .DrawX(a_x), .DrawY(a_y),
    .hs(a_hs), .vs(a_vs), .blank(a_blank), .line_start(a_ls), .frame_start(a_fs), .frame_count(a_fc));
  vga_timing_gen #(.SYNC_DELAY(0)) db (.Clk(Clk), .Reset(Reset), .vga_clk(b_vclk), .DrawX(b_x), .DrawY(b_y),
    .hs(b_hs), .vs(b_vs), .blank(b_blank), .line_start(b_ls), .frame_start(b_fs), .frame_count(b_fc));
  vga_timing_gen #(.SYNC_DELAY(3)) dc (.Clk(Clk), .Reset(Reset), .vga_clk(c_vclk), .DrawX(c_x), .DrawY(c_y),
    .hs(c_hs), .vs(c_vs), .blank(c_blank), .line_start(c_ls), .frame_start(c_fs), .frame_count(c_fc));
  // 8 x 7 raster: line = 16 Clk, frame = 112 Clk
  vga_timing_gen #(.H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1), .V_VISIBLE(3), .V_FRONT(1),
    .V_SYNC(2), .V_BACK(1), .SYNC_DELAY(1)) ds (.Clk(Clk), .Reset(Reset), .vga_clk(s_vclk), .DrawX(s_x),
    .DrawY(s_y), .hs(s_hs), .vs(s_vs), .blank(s_blank), .line_start(s_ls), .frame_start(s_fs), .frame_count(s_fc));
  int n_chk = 0;
  int n_fail = 0;
  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  int a_ls_n = 0, a_hs_lo = 0, a_fs_n = 0, vclk_bad = 0;
  int s_fs_n = 0, s_fs_bad = 0, s_blank_bad = 0, s_xmax = 0, s_ymax = 0, post_fs = 0;
  initial begin
    repeat (3) @(posedge Clk);
    #1;
    check("rst_x", a_x, 0);
    check("rst_y", a_y, 0);
    check("rst_vclk", a_vclk, 0);
    check("rst_hs", a_hs, 1);
    check("rst_vs", a_vs, 1);
    check("rst_blank", a_blank, 0);
    check("rst_ls", a_ls, 0);
    check("rst_fs", a_fs, 0);
    check("rst_fc", a_fc, 0);
    check("rst_d3_blank", c_blank, 0);
    Reset = 1'b0;
    for (int cyc = 1; cyc <= 28858; cyc++) begin
      @(posedge Clk);
      #1;
      if (a_vclk != cyc[0]) vclk_bad++;
      if (cyc <= 3200 && a_ls) a_ls_n++;
      if (cyc > 1600 && cyc <= 3200 && !a_hs) a_hs_lo++;
      if (a_fs) a_fs_n++;
      if (s_fs && cyc <= 28672) s_fs_n++;
      if (s_fs && !s_ls) s_fs_bad++;
      if (s_y >= 3 && s_blank) s_blank_bad++;
      if (int'(s_x) > s_xmax) s_xmax = s_x;
      if (int'(s_y) > s_ymax) s_ymax = s_y;
      case (cyc)
        2: begin check("x_at_2", a_x, 1); check("blank_at_2", a_blank, 1); end
        5: check("d3_blank_at_5", c_blank, 0);
        6: check("d3_blank_at_6", c_blank, 1);
        65: check("s_vs_at_65", s_vs, 1);
        66: check("s_vs_at_66", s_vs, 0);
        97: check("s_vs_at_97", s_vs, 0);
        98: check("s_vs_at_98", s_vs, 1);
        111: begin check("s_fs_at_111", s_fs, 0); check("s_fc_at_111", s_fc, 0); end
        112: begin
          check("s_fs_at_112", s_fs, 1);
          check("s_ls_at_112", s_ls, 1);
          check("s_fc_at_112", s_fc, 1);
          check("s_x_at_112", s_x, 0);
          check("s_y_at_112", s_y, 0);
        end
        113: check("s_fs_at_113", s_fs, 0);
        224: begin check("s_fs_at_224", s_fs, 1); check("s_fc_at_224", s_fc, 2); end
        1278: check("x_at_1278", a_x, 639);
        1279: check("d0_blank_at_1279", b_blank, 1);
        1280: begin check("d0_blank_at_1280", b_blank, 0); check("x_at_1280", a_x, 640); end
        1281: check("blank_at_1281", a_blank, 1);
        1282: check("blank_at_1282", a_blank, 0);
        1285: check("d3_blank_at_1285", c_blank, 1);
        1286: check("d3_blank_at_1286", c_blank, 0);
        1312: check("x_at_1312", a_x, 656);
        1313: check("hs_at_1313", a_hs, 1);
        1314: check("hs_at_1314", a_hs, 0);
        1505: check("hs_at_1505", a_hs, 0);
        1506: check("hs_at_1506", a_hs, 1);
        1599: check("ls_at_1599", a_ls, 0);
        1600: begin check("ls_at_1600", a_ls, 1); check("x_at_1600", a_x, 0); check("y_at_1600", a_y, 1); end
        1601: check("ls_at_1601", a_ls, 0);
        3200: begin check("ls_at_3200", a_ls, 1); check("y_at_3200", a_y, 2); end
        28671: check("s_fc_at_255", s_fc, 255);
        28672: begin check("s_fs_wrap", s_fs, 1); check("s_fc_wrap", s_fc, 0); end
        28858: begin
          check("pre_rst_x", s_x, 5);
          check("pre_rst_y", s_y, 4);
          check("pre_rst_fc", s_fc, 1);
          check("pre_rst_vs", s_vs, 0);
        end
        default: ;
      endcase
    end
    check("vclk_toggle_errs", vclk_bad, 0);
    check("ls_count", a_ls_n, 2);
    check("hs_low_clks", a_hs_lo, 192);
    check("no_early_fs", a_fs_n, 0);
    check("s_fs_count", s_fs_n, 256);
    check("fs_without_ls", s_fs_bad, 0);
    check("s_blank_in_vblank", s_blank_bad, 0);
    check("s_x_max", s_xmax, 7);
    check("s_y_max", s_ymax, 6);
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    check("mid_rst_x", s_x, 0);
    check("mid_rst_y", s_y, 0);
    check("mid_rst_fc", s_fc, 0);
    check("mid_rst_hs", s_hs, 1);
    check("mid_rst_vs", s_vs, 1);
    check("mid_rst_blank", s_blank, 0);
    check("mid_rst_fs", s_fs, 0);
    check("mid_rst_ls", s_ls, 0);
    check("mid_rst_vclk", s_vclk, 0);
    check("mid_rst_a_x", a_x, 0);
    Reset = 1'b0;
    repeat (20) begin
      @(posedge Clk);
      #1;
      if (s_fs) post_fs++;
    end
    check("post_rst_no_fs", post_fs, 0);
    check("post_rst_x", s_x, 2);
    check("post_rst_y", s_y, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
